// File: rtl/riscv_pkg.sv
// Types and constants shared by the RV32I pipeline stages and the hazard controller.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_RTYPE  = 7'b0110011,
    OPC_ITYPE  = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries between instruction memory and the IF/ID register.
// Clear wins over push and pop so a redirect empties the queue in one edge.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty    = (count == '0);
    full     = (count == CW'(DEPTH));
    do_push  = push & ~full & ~clear;
    do_pop   = pop & ~empty & ~clear;
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC generation, credit-limited instruction fetch, prefetch FIFO and IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  input  logic        pc_enable,
  input  logic        stall_ID,
  input  logic        flush_ID,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_pop;
  logic            fifo_push;
  logic            accept;
  logic            resp_valid;
  fetch_entry_t    fifo_wdata;
  fetch_entry_t    fifo_rdata;

  // A slot freed by this edge's pop counts as available, which keeps a
  // 1-cycle memory streaming at one instruction per cycle.
  always_comb begin
    fifo_pop         = flush_ID & stall_ID & ~fifo_empty;
    credit_used      = {1'b0, fifo_count} + {1'b0, outstanding} - {CW'(0), fifo_pop};
    o_imem_req       = ~i_reset & pc_enable & ~i_pc_sel &
                       (credit_used < (CW+1)'(FIFO_DEPTH));
    o_imem_addr      = pc;
    accept           = o_imem_req & i_imem_gnt;
    resp_valid       = i_imem_rvalid & (outstanding != '0);
    fifo_push        = resp_valid & (discard == '0) & ~i_pc_sel & ~fifo_full;
    fifo_wdata.pc    = pc - (XLEN'(outstanding) << 2);
    fifo_wdata.instr = i_imem_rdata;
  end

  // On redirect every response still in flight belongs to the old stream.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(resp_valid);
      if (i_pc_sel) begin
        pc      <= i_alu_data;
        discard <= outstanding - CW'(resp_valid);
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (resp_valid && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_reset),
    .clear     (i_pc_sel),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Flush dominates stall; an empty FIFO yields a bubble.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_id_valid <= 1'b0;
      o_id_pc    <= '0;
      o_id_instr <= NOP_INSTR;
    end else if (!flush_ID) begin
      o_id_valid <= 1'b0;
      o_id_pc    <= '0;
      o_id_instr <= NOP_INSTR;
    end else if (!stall_ID) begin
      o_id_valid <= o_id_valid;
    end else if (!fifo_empty) begin
      o_id_valid <= 1'b1;
      o_id_pc    <= fifo_rdata.pc;
      o_id_instr <= fifo_rdata.instr;
    end else begin
      o_id_valid <= 1'b0;
      o_id_pc    <= '0;
      o_id_instr <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table with a 1-cycle memory, then
// hand sequences for 3-cycle latency with redirect and reset with a stale response.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_pc_sel;
  logic [31:0] i_alu_data;
  logic        pc_enable;
  logic        stall_ID;
  logic        flush_ID;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_id_valid;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_instr;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_pc_sel      (i_pc_sel),
    .i_alu_data    (i_alu_data),
    .pc_enable     (pc_enable),
    .stall_ID      (stall_ID),
    .flush_ID      (flush_ID),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_id_valid    (o_id_valid),
    .o_id_pc       (o_id_pc),
    .o_id_instr    (o_id_instr)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: in-order responses, mem_lat cycles after the grant edge.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  int          mem_lat = 1;
  logic        mem_auto = 1'b1;
  logic        mem_gnt = 1'b1;
  logic        auto_rvalid = 1'b0;
  logic [31:0] auto_rdata = '0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0;

  assign i_imem_gnt    = mem_gnt;
  assign i_imem_rvalid = mem_auto ? auto_rvalid : man_rvalid;
  assign i_imem_rdata  = mem_auto ? auto_rdata  : man_rdata;

  always @(posedge i_clk) begin
    if (i_reset) pend.delete();
    else if (mem_auto && o_imem_req && i_imem_gnt)
      pend.push_back('{addr: o_imem_addr, due: cyc + mem_lat});
    cyc <= cyc + 1;
  end

  always @(negedge i_clk) begin
    if (mem_auto && pend.size() > 0 && pend[0].due <= cyc) begin
      auto_rvalid <= 1'b1;
      auto_rdata  <= instr_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      auto_rvalid <= 1'b0;
      auto_rdata  <= '0;
    end
  end

  typedef struct {
    logic        en;
    logic        stall_n;
    logic        flush_n;
    logic        sel;
    logic [31:0] alu;
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic en, input logic st, input logic fl, input logic sel,
                        input logic [31:0] alu, input logic req, input logic vld,
                        input logic [31:0] pc);
    vecs.push_back('{en, st, fl, sel, alu, req, vld, pc});
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_reset    = 1'b0;
    pc_enable  = v.en;
    stall_ID   = v.stall_n;
    flush_ID   = v.flush_n;
    i_pc_sel   = v.sel;
    i_alu_data = v.alu;
  endtask

  task automatic checkId(input string tag, input logic vld, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, 32'(o_id_valid), 32'(vld));
    checkOutput({tag, "_pc"}, o_id_pc, vld ? pc : 32'h0);
    checkOutput({tag, "_instr"}, o_id_instr, vld ? instr_of(pc) : NOP_INSTR);
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_reset   = 1'b1;
    i_pc_sel  = 1'b0;
    stall_ID  = 1'b1;
    flush_ID  = 1'b1;
    pc_enable = 1'b1;
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] exp_next;
    int          nvalid;
    int          nbubble;
    int          inflight;
    int          max_inflight;
    int          waited;
    int          got;

    i_reset    = 1'b1;
    pc_enable  = 1'b1;
    stall_ID   = 1'b1;
    flush_ID   = 1'b1;
    i_pc_sel   = 1'b0;
    i_alu_data = '0;

    //      en st fl sel alu           req vld pc
    addVec(H, H, H, L, 32'h0,         H, L, 32'h0);
    addVec(H, H, H, L, 32'h0,         H, L, 32'h0);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h0);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h4);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h8);
    addVec(H, L, H, L, 32'h0,         L, H, 32'h8);
    addVec(H, L, H, L, 32'h0,         L, H, 32'h8);
    addVec(H, L, H, L, 32'h0,         L, H, 32'h8);
    addVec(H, H, H, L, 32'h0,         H, H, 32'hC);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h10);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h14);
    addVec(H, H, L, H, 32'h100,       L, L, 32'h0);
    addVec(H, H, H, L, 32'h0,         H, L, 32'h0);
    addVec(H, H, H, L, 32'h0,         H, L, 32'h0);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h100);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h104);
    addVec(H, L, L, L, 32'h0,         L, L, 32'h0);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h108);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h10C);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h110);
    addVec(L, H, L, H, 32'hFFFF_FFF8, L, L, 32'h0);
    addVec(H, H, H, L, 32'h0,         H, L, 32'h0);
    addVec(H, H, H, L, 32'h0,         H, L, 32'h0);
    addVec(H, H, H, L, 32'h0,         H, H, 32'hFFFF_FFF8);
    addVec(H, H, H, L, 32'h0,         H, H, 32'hFFFF_FFFC);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h0);
    addVec(H, H, H, L, 32'h0,         H, H, 32'h4);

    repeat (2) @(negedge i_clk);
    #1;
    checkOutput("reset_req", 32'(o_imem_req), 32'h0);
    checkOutput("reset_addr", o_imem_addr, 32'h0);
    checkId("reset_id", 1'b0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge i_clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d_req", i + 1), 32'(o_imem_req), 32'(vecs[i].exp_req));
      @(posedge i_clk);
      #1;
      checkId($sformatf("row%0d_id", i + 1), vecs[i].exp_valid, vecs[i].exp_pc);
    end

    // 3-cycle memory: contiguous PCs with bubbles, then redirect with two in flight.
    mem_lat = 3;
    doReset();
    i_reset      = 1'b0;
    exp_next     = 32'h0;
    nvalid       = 0;
    nbubble      = 0;
    max_inflight = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge i_clk);
      #1;
      inflight = pend.size() + int'(auto_rvalid);
      if (inflight > max_inflight) max_inflight = inflight;
      @(posedge i_clk);
      #1;
      if (o_id_valid) begin
        checkOutput("lat3_pc", o_id_pc, exp_next);
        checkOutput("lat3_instr", o_id_instr, instr_of(exp_next));
        exp_next = exp_next + 32'd4;
        nvalid++;
      end else if (nvalid > 0) begin
        nbubble++;
      end
    end
    checkOutput("lat3_max_inflight", 32'(max_inflight), 32'd2);
    checkOutput("lat3_progress", 32'(nvalid >= 3), 32'd1);
    checkOutput("lat3_bubbles", 32'(nbubble > 0), 32'd1);

    waited = 0;
    do begin
      @(negedge i_clk);
      #1;
      inflight = pend.size() + int'(auto_rvalid);
      waited++;
    end while (inflight != 2 && waited < 20);
    checkOutput("redir_two_in_flight", 32'(inflight), 32'd2);
    i_pc_sel   = 1'b1;
    i_alu_data = 32'h100;
    flush_ID   = 1'b0;
    #1;
    checkOutput("redir_req_blocked", 32'(o_imem_req), 32'h0);
    @(posedge i_clk);
    #1;
    checkId("redir_bubble", 1'b0, 32'h0);
    @(negedge i_clk);
    i_pc_sel = 1'b0;
    flush_ID = 1'b1;
    exp_next = 32'h100;
    got      = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(posedge i_clk);
      #1;
      if (o_id_valid) begin
        checkOutput("redir_pc", o_id_pc, exp_next);
        checkOutput("redir_instr", o_id_instr, instr_of(exp_next));
        exp_next = exp_next + 32'd4;
        got++;
      end
    end
    checkOutput("redir_count", 32'(got), 32'd4);

    // Reset mid-stream with one fetch outstanding; its late response must be ignored.
    mem_auto   = 1'b0;
    mem_gnt    = 1'b0;
    man_rvalid = 1'b0;
    doReset();
    i_reset = 1'b0;
    mem_gnt = 1'b1;
    #1;
    checkOutput("mid_first_req", 32'(o_imem_req), 32'h1);
    checkOutput("mid_first_addr", o_imem_addr, 32'h0);
    @(negedge i_clk);
    man_rvalid = 1'b1;
    man_rdata  = instr_of(32'h0);
    @(negedge i_clk);
    man_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    pc_enable  = 1'b0;
    @(posedge i_clk);
    #1;
    checkId("mid_stream_id", 1'b1, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    checkOutput("mid_reset_req", 32'(o_imem_req), 32'h0);
    checkId("mid_reset_id", 1'b0, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    man_rvalid = 1'b1;
    man_rdata  = 32'hBAD0_0BAD;
    @(posedge i_clk);
    #1;
    checkId("stale_edge_id", 1'b0, 32'h0);
    @(negedge i_clk);
    man_rvalid = 1'b0;
    pc_enable  = 1'b1;
    mem_gnt    = 1'b1;
    #1;
    checkOutput("post_reset_req", 32'(o_imem_req), 32'h1);
    checkOutput("post_reset_addr", o_imem_addr, 32'h0);
    @(posedge i_clk);
    #1;
    checkId("stale_dropped_id", 1'b0, 32'h0);
    @(negedge i_clk);
    pc_enable  = 1'b0;
    mem_gnt    = 1'b0;
    man_rvalid = 1'b1;
    man_rdata  = instr_of(32'h0);
    @(posedge i_clk);
    #1;
    checkId("no_bypass_id", 1'b0, 32'h0);
    @(negedge i_clk);
    man_rvalid = 1'b0;
    @(posedge i_clk);
    #1;
    checkId("post_reset_id", 1'b1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
